fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the decoder and drives the read side of the 8K x 8 unified memory. It sequences one or two byte reads per instruction and assembles the bytes into a 16-bit instruction word. It presents the word to the decoder with a valid/ready handshake. The fetch unit yields the memory port to the execute stage on request and accepts taken-branch redirects.

Parameters:
ADDR_W, 13, memory address width and program counter width; the program counter wraps modulo 2^ADDR_W.
DATA_W, 8, memory data width (one instruction byte).
RESET_PC, 0, program counter value loaded on reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset.
mem_addr  out  ADDR_W  memory address, driven combinationally from state.
mem_read  out  1  memory read enable, driven combinationally.
mem_rd  in  DATA_W  memory read data; combinational (same-cycle) relative to mem_addr/mem_read.
data_req  in  1  execute stage owns the memory port this cycle; fetch must release it.
jump_valid  in  1  single-cycle redirect strobe.
jump_addr  in  ADDR_W  redirect target.
instr  out  16  assembled instruction: [15:8] = byte0, [7:0] = byte1, or 0 for one-byte instructions.
instr_len  out  1  0 = one-byte instruction, 1 = two-byte instruction.
instr_pc  out  ADDR_W  address of byte0 of the presented instruction.
instr_valid  out  1  instruction available to the decoder.
instr_ready  in  1  decoder accepts the instruction.

Behaviour:
- Reset (rst low, asynchronous) sets:
  - pc = RESET_PC; state = F0.
  - instr = 0, instr_len = 0, instr_pc = RESET_PC, instr_valid = 0.
  - mem_read = 0 (gated by rst low), mem_addr = RESET_PC.
- States:
  - F0: read byte0.
  - F1: read byte1.
  - HOLD: instruction presented to the decoder.
- mem_addr:
  - F0: pc.
  - F1: pc+1, computed modulo 2^ADDR_W.
  - HOLD: pc.
- mem_read = 1 only in F0/F1 with data_req = 0 and rst high; otherwise 0.
- F0, data_req = 1: hold all state.
- F0, data_req = 0:
  - Latch instr[15:8] = mem_rd and instr_pc = pc.
  - If mem_rd[7] = 1: go to F1.
  - Else (one-byte instruction): instr[7:0] = 0, instr_len = 0, instr_valid = 1, pc = pc+1, go to HOLD.
- F1, data_req = 1: hold all state; byte0 is retained.
- F1, data_req = 0: instr[7:0] = mem_rd, instr_len = 1, instr_valid = 1, pc = pc+2, go to HOLD.
- HOLD:
  - instr, instr_len and instr_pc stay stable while instr_valid = 1 and instr_ready = 0.
  - On instr_ready = 1: instr_valid = 0 at the next edge and the state goes to F0.
  - data_req has no effect in HOLD.
- Latency and throughput:
  - One-byte instruction: instr_valid asserts 1 edge after the F0 read.
  - Two-byte instruction: instr_valid asserts 2 edges after the F0 read.
  - Peak rate: one instruction per 2 cycles (one-byte) or per 3 cycles (two-byte).
- Redirect: jump_valid = 1 in any state has the highest priority, above data_req and instr_ready.
  - Sets pc = jump_addr, instr_valid = 0, state = F0.
  - Any partially fetched byte0 is discarded.
  - jump_valid together with instr_ready in HOLD: the presented instruction counts as consumed; the redirect still applies.
- Wrap-around:
  - pc = 2^ADDR_W-1 with a two-byte opcode: byte1 is read from address 0.
  - The resulting pc is 1.
- Reset mid-operation: all state returns to reset values immediately; no partial instruction survives.
- Write-side memory signals are not driven by this block.

Test Plan:
- Reset, mem[0] = 0x43 -> cycle 1: mem_addr = 0, mem_read = 1; next edge: instr = 0x4300, instr_len = 0, instr_pc = 0, instr_valid = 1, pc = 1.
- mem[1] = 0xE8, mem[2] = 0x03, instr_ready tied 1 -> instr = 0xE803, instr_len = 1, instr_pc = 1, valid for exactly 1 cycle; the next fetch reads address 3.
- Backpressure: instr_ready = 0 for 5 cycles after valid -> instr stable, mem_read = 0, pc unchanged; ready = 1 -> valid drops on the next edge.
- data_req = 1 for 3 cycles while in F1 with byte0 = 0xF0 -> mem_read = 0 during the stall; afterwards byte1 is read from pc+1 and instr = 0xF0xx with correct byte0.
- jump_valid with jump_addr = 1000 while in F1 -> no instr_valid for the aborted instruction; the next mem_addr is 1000 in F0.
- Wrap and reset: RESET_PC = 8191, mem[8191] = 0xE9, mem[0] = 0x0F -> instr = 0xE90F, pc = 1. Separately, rst low mid-F1 -> instr_valid = 0 and mem_read = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads one or two bytes per instruction from the unified
// memory and presents the assembled 16-bit word to the decoder over valid/ready.
module fetch_unit #(
  parameter int                ADDR_W   = 13,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_read,
  input  logic [DATA_W-1:0]   mem_rd,
  input  logic                data_req,
  input  logic                jump_valid,
  input  logic [ADDR_W-1:0]   jump_addr,
  output logic [2*DATA_W-1:0] instr,
  output logic                instr_len,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic                instr_valid,
  input  logic                instr_ready
);

  typedef enum logic [1:0] {
    F0   = 2'd0,
    F1   = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_TWO = ADDR_W'(2);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [2*DATA_W-1:0] instr_q, instr_d;
  logic                len_q, len_d;
  logic [ADDR_W-1:0]   ipc_q, ipc_d;
  logic                valid_q, valid_d;

  logic [ADDR_W-1:0]   pc_plus1;
  logic [ADDR_W-1:0]   pc_plus2;
  logic                fetching;

  // Address arithmetic wraps naturally at ADDR_W bits.
  assign pc_plus1 = pc_q + PC_ONE;
  assign pc_plus2 = pc_q + PC_TWO;
  assign fetching = (state_q == F0) || (state_q == F1);

  always_comb begin
    mem_addr = pc_q;
    if (state_q == F1) begin
      mem_addr = pc_plus1;
    end
  end

  // Read is gated by reset so the port is released while rst is low.
  assign mem_read = fetching && !data_req && rst;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    len_d   = len_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;

    if (jump_valid) begin
      pc_d    = jump_addr;
      valid_d = 1'b0;
      state_d = F0;
    end else begin
      unique case (state_q)
        F0: begin
          if (!data_req) begin
            instr_d[2*DATA_W-1:DATA_W] = mem_rd;
            ipc_d                      = pc_q;
            if (mem_rd[DATA_W-1]) begin
              state_d = F1;
            end else begin
              instr_d[DATA_W-1:0] = '0;
              len_d               = 1'b0;
              valid_d             = 1'b1;
              pc_d                = pc_plus1;
              state_d             = HOLD;
            end
          end
        end
        F1: begin
          if (!data_req) begin
            instr_d[DATA_W-1:0] = mem_rd;
            len_d               = 1'b1;
            valid_d             = 1'b1;
            pc_d                = pc_plus2;
            state_d             = HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            valid_d = 1'b0;
            state_d = F0;
          end
        end
        default: begin
          valid_d = 1'b0;
          state_d = F0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= F0;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      len_q   <= 1'b0;
      ipc_q   <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      len_q   <= len_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  assign instr       = instr_q;
  assign instr_len   = len_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural memories, a scoreboard of expected
// instructions popped on each decoder handshake, and a second instance reset to the top address.
module tb_fetch_unit;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [15:0]       word;
    logic              len;
    logic [ADDR_W-1:0] pc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem  [DEPTH];
  logic [DATA_W-1:0] mem2 [DEPTH];

  // main instance
  logic              rst, data_req, jump_valid, instr_ready;
  logic [ADDR_W-1:0] jump_addr, mem_addr, instr_pc;
  logic              mem_read, instr_len, instr_valid;
  logic [DATA_W-1:0] mem_rd;
  logic [15:0]       instr;

  // wrap instance
  logic              rst2, ready2;
  logic [ADDR_W-1:0] mem_addr2, instr_pc2;
  logic              mem_read2, instr_len2, instr_valid2;
  logic [DATA_W-1:0] mem_rd2;
  logic [15:0]       instr2;

  assign mem_rd  = mem[mem_addr];
  assign mem_rd2 = mem2[mem_addr2];

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(13'd0)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_read(mem_read), .mem_rd(mem_rd),
    .data_req(data_req), .jump_valid(jump_valid), .jump_addr(jump_addr),
    .instr(instr), .instr_len(instr_len), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(13'd8191)) dut_wrap (
    .clk(clk), .rst(rst2), .mem_addr(mem_addr2), .mem_read(mem_read2), .mem_rd(mem_rd2),
    .data_req(1'b0), .jump_valid(1'b0), .jump_addr(13'd0),
    .instr(instr2), .instr_len(instr_len2), .instr_pc(instr_pc2),
    .instr_valid(instr_valid2), .instr_ready(ready2)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w, input logic l, input logic [ADDR_W-1:0] p);
    exp_t e;
    e.word = w;
    e.len  = l;
    e.pc   = p;
    sb.push_back(e);
  endtask

  // Scoreboard: every accepted instruction must match the next expected entry.
  always @(negedge clk) begin
    if (rst && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_instr", {16'd0, instr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_word", {16'd0, instr}, {16'd0, e.word});
        chk("sb_len", {31'd0, instr_len}, {31'd0, e.len});
        chk("sb_pc", {19'd0, instr_pc}, {19'd0, e.pc});
        $display("handshake pc=%0d instr=%04h len=%0d", instr_pc, instr, instr_len);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = '0;
      mem2[i] = '0;
    end
    mem[0]    = 8'h43;
    mem[1]    = 8'hE8;
    mem[2]    = 8'h03;
    mem[3]    = 8'hF0;
    mem[4]    = 8'h55;
    mem[5]    = 8'h81;
    mem[6]    = 8'h77;
    mem[1000] = 8'h12;
    mem[1001] = 8'h00;
    mem[1002] = 8'h80;
    mem[1003] = 8'h44;
    mem2[8191] = 8'hE9;
    mem2[0]    = 8'h0F;

    rst = 1'b0; rst2 = 1'b0; ready2 = 1'b0;
    data_req = 1'b0; jump_valid = 1'b0; jump_addr = '0; instr_ready = 1'b1;

    // reset state
    tick(); tick();
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_addr", {19'd0, mem_addr}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, instr}, 32'd0);
    chk("rst_instr_pc", {19'd0, instr_pc}, 32'd0);

    // one-byte then two-byte instruction with ready tied high
    push(16'h4300, 1'b0, 13'd0);
    push(16'hE803, 1'b1, 13'd1);
    rst = 1'b1;
    #1;
    chk("f0_mem_addr", {19'd0, mem_addr}, 32'd0);
    chk("f0_mem_read", {31'd0, mem_read}, 32'd1);
    tick();
    chk("one_byte_valid", {31'd0, instr_valid}, 32'd1);
    chk("one_byte_instr", {16'd0, instr}, 32'h4300);
    chk("one_byte_len", {31'd0, instr_len}, 32'd0);
    chk("hold_mem_addr_pc1", {19'd0, mem_addr}, 32'd1);
    chk("hold_mem_read", {31'd0, mem_read}, 32'd0);
    tick();
    chk("after_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("f0_addr1", {19'd0, mem_addr}, 32'd1);
    tick();
    chk("f1_addr2", {19'd0, mem_addr}, 32'd2);
    tick();
    chk("two_byte_valid", {31'd0, instr_valid}, 32'd1);
    chk("two_byte_instr", {16'd0, instr}, 32'hE803);
    tick();
    chk("two_byte_valid_one_cycle", {31'd0, instr_valid}, 32'd0);
    chk("next_fetch_addr3", {19'd0, mem_addr}, 32'd3);

    // data_req stall in F1 with byte0 = F0, then backpressure in HOLD
    instr_ready = 1'b0;
    push(16'hF055, 1'b1, 13'd3);
    tick();
    chk("f1_addr4", {19'd0, mem_addr}, 32'd4);
    data_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_mem_read", {31'd0, mem_read}, 32'd0);
      chk("stall_mem_addr", {19'd0, mem_addr}, 32'd4);
      chk("stall_valid", {31'd0, instr_valid}, 32'd0);
      tick();
    end
    data_req = 1'b0;
    #1;
    chk("stall_release_read", {31'd0, mem_read}, 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, instr_valid}, 32'd1);
      chk("bp_instr", {16'd0, instr}, 32'hF055);
      chk("bp_mem_read", {31'd0, mem_read}, 32'd0);
      chk("bp_pc", {19'd0, mem_addr}, 32'd5);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, instr_valid}, 32'd0);
    chk("bp_release_addr", {19'd0, mem_addr}, 32'd5);

    // redirect while in F1 aborts the partial instruction
    tick();
    chk("pre_jump_f1_addr", {19'd0, mem_addr}, 32'd6);
    jump_valid = 1'b1;
    jump_addr  = 13'd1000;
    tick();
    jump_valid = 1'b0;
    chk("jump_no_valid", {31'd0, instr_valid}, 32'd0);
    chk("jump_mem_addr", {19'd0, mem_addr}, 32'd1000);
    chk("jump_mem_read", {31'd0, mem_read}, 32'd1);
    push(16'h1200, 1'b0, 13'd1000);
    push(16'h0000, 1'b0, 13'd1001);
    tick();
    chk("jump_target_instr", {16'd0, instr}, 32'h1200);
    tick(); tick(); tick();
    tick();
    chk("pre_reset_f1_addr", {19'd0, mem_addr}, 32'd1003);

    // asynchronous reset mid-F1
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("async_rst_mem_addr", {19'd0, mem_addr}, 32'd0);
    chk("async_rst_instr", {16'd0, instr}, 32'd0);
    tick();
    push(16'h4300, 1'b0, 13'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_instr", {16'd0, instr}, 32'h4300);
    tick();
    instr_ready = 1'b0;

    // wrap-around instance
    rst2 = 1'b1;
    #1;
    chk("wrap_f0_addr", {19'd0, mem_addr2}, 32'd8191);
    tick();
    chk("wrap_f1_addr", {19'd0, mem_addr2}, 32'd0);
    tick();
    chk("wrap_valid", {31'd0, instr_valid2}, 32'd1);
    chk("wrap_instr", {16'd0, instr2}, 32'hE90F);
    chk("wrap_instr_pc", {19'd0, instr_pc2}, 32'd8191);
    chk("wrap_len", {31'd0, instr_len2}, 32'd1);
    chk("wrap_pc", {19'd0, mem_addr2}, 32'd1);
    ready2 = 1'b1;
    tick();
    chk("wrap_next_addr", {19'd0, mem_addr2}, 32'd1);
    tick(); tick();

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
